// File: rtl/rom_load_pkg.sv
// Shared types and default geometry for the ROM download sequencer.
// Region bases and image size are byte addresses in the flat download stream.
package rom_load_pkg;
  localparam int ADDR_W          = 25;
  localparam int NUM_REGIONS     = 4;
  localparam int DEF_HOLD_CYCLES = 16;

  localparam logic [ADDR_W-1:0] DEF_R1_BASE    = 25'h0C000;
  localparam logic [ADDR_W-1:0] DEF_R2_BASE    = 25'h10000;
  localparam logic [ADDR_W-1:0] DEF_R3_BASE    = 25'h20000;
  localparam logic [ADDR_W-1:0] DEF_TOTAL_SIZE = 25'h20220;

  typedef logic [1:0] region_idx_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_DRAIN,
    S_CHECK,
    S_HOLD,
    S_RUN,
    S_ERROR
  } state_t;
endpackage

// File: rtl/rom_region_decode.sv
// Flat address to region one-hot, in-region offset and out-of-image flag.
// Purely combinational: no latency, no backpressure.
module rom_region_decode
  import rom_load_pkg::*;
#(
  parameter logic [ADDR_W-1:0] R1_BASE    = DEF_R1_BASE,
  parameter logic [ADDR_W-1:0] R2_BASE    = DEF_R2_BASE,
  parameter logic [ADDR_W-1:0] R3_BASE    = DEF_R3_BASE,
  parameter logic [ADDR_W-1:0] TOTAL_SIZE = DEF_TOTAL_SIZE
) (
  input  logic [ADDR_W-1:0]      i_addr,
  output logic [NUM_REGIONS-1:0] o_region_oh,
  output logic [ADDR_W-1:0]      o_offset,
  output logic                   o_illegal
);
  region_idx_t       w_region;
  logic [ADDR_W-1:0] w_base;

  always_comb begin
    w_region = 2'd0;
    w_base   = '0;
    if (i_addr >= R3_BASE) begin
      w_region = 2'd3;
      w_base   = R3_BASE;
    end else if (i_addr >= R2_BASE) begin
      w_region = 2'd2;
      w_base   = R2_BASE;
    end else if (i_addr >= R1_BASE) begin
      w_region = 2'd1;
      w_base   = R1_BASE;
    end
  end

  assign o_region_oh = NUM_REGIONS'(1) << w_region;
  assign o_offset    = i_addr - w_base;
  assign o_illegal   = (i_addr >= TOTAL_SIZE);
endmodule

// File: rtl/rom_load_sequencer.sv
// Turns the HPS download byte stream into acknowledged per-region ROM writes; write issued 1 cycle
// after ioctl_wr, ioctl_wait held while the single-entry buffer is occupied; gates core reset on a clean load.
module rom_load_sequencer
  import rom_load_pkg::*;
#(
  parameter logic [ADDR_W-1:0] R1_BASE     = DEF_R1_BASE,
  parameter logic [ADDR_W-1:0] R2_BASE     = DEF_R2_BASE,
  parameter logic [ADDR_W-1:0] R3_BASE     = DEF_R3_BASE,
  parameter logic [ADDR_W-1:0] TOTAL_SIZE  = DEF_TOTAL_SIZE,
  parameter int                HOLD_CYCLES = DEF_HOLD_CYCLES
) (
  input  logic                   i_clk_sys,
  input  logic                   i_reset_n,
  input  logic                   i_ioctl_download,
  input  logic                   i_ioctl_wr,
  input  logic [ADDR_W-1:0]      i_ioctl_addr,
  input  logic [7:0]             i_ioctl_dout,
  output logic                   o_ioctl_wait,
  output logic [NUM_REGIONS-1:0] o_rom_we,
  output logic [ADDR_W-1:0]      o_rom_addr,
  output logic [7:0]             o_rom_data,
  input  logic                   i_rom_ack,
  output logic                   o_core_rst,
  output logic                   o_load_done,
  output logic                   o_load_err
);
  localparam int HOLD_W = $clog2(HOLD_CYCLES + 1);

  state_t                   r_state, w_next;
  logic                     r_dl_q;
  logic                     r_full;
  logic [NUM_REGIONS-1:0]   r_we;
  logic [ADDR_W-1:0]        r_addr;
  logic [7:0]               r_data;
  logic [ADDR_W-1:0]        r_count;
  logic                     r_err;
  logic [HOLD_W-1:0]        r_hold;

  logic [NUM_REGIONS-1:0]   w_dec_oh;
  logic [ADDR_W-1:0]        w_dec_offset;
  logic                     w_dec_illegal;
  logic                     w_dl_rise, w_ack, w_free, w_capture, w_bad_wr;

  rom_region_decode #(
    .R1_BASE    (R1_BASE),
    .R2_BASE    (R2_BASE),
    .R3_BASE    (R3_BASE),
    .TOTAL_SIZE (TOTAL_SIZE)
  ) u_decode (
    .i_addr      (i_ioctl_addr),
    .o_region_oh (w_dec_oh),
    .o_offset    (w_dec_offset),
    .o_illegal   (w_dec_illegal)
  );

  // An ack frees the buffer in the same cycle, so a back-to-back byte is not an overrun.
  assign w_dl_rise = i_ioctl_download & ~r_dl_q;
  assign w_ack     = r_full & i_rom_ack;
  assign w_free    = ~r_full | i_rom_ack;
  assign w_capture = (r_state == S_LOAD) & i_ioctl_wr & ~w_dec_illegal & w_free;
  assign w_bad_wr  = (r_state == S_LOAD) & i_ioctl_wr & (w_dec_illegal | ~w_free);

  always_ff @(posedge i_clk_sys or negedge i_reset_n) begin
    if (!i_reset_n) r_state <= S_IDLE;
    else            r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (w_dl_rise) begin
      w_next = S_LOAD;
    end else begin
      case (r_state)
        S_LOAD:  if (!i_ioctl_download) w_next = S_DRAIN;
        S_DRAIN: if (!r_full) w_next = S_CHECK;
        S_CHECK: w_next = (r_count == TOTAL_SIZE && !r_err) ? S_HOLD : S_ERROR;
        S_HOLD:  if (r_hold == HOLD_W'(HOLD_CYCLES - 1)) w_next = S_RUN;
        default: w_next = r_state;
      endcase
    end
  end

  always_comb begin
    o_core_rst  = 1'b1;
    o_load_done = 1'b0;
    if (r_state == S_RUN) begin
      o_core_rst  = 1'b0;
      o_load_done = 1'b1;
    end
  end

  always_ff @(posedge i_clk_sys or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_dl_q  <= 1'b0;
      r_full  <= 1'b0;
      r_we    <= '0;
      r_addr  <= '0;
      r_data  <= '0;
      r_count <= '0;
      r_err   <= 1'b0;
      r_hold  <= '0;
    end else begin
      r_dl_q <= i_ioctl_download;
      if (w_ack) begin
        r_full <= 1'b0;
        r_we   <= '0;
      end
      if (w_capture) begin
        r_full <= 1'b1;
        r_we   <= w_dec_oh;
        r_addr <= w_dec_offset;
        r_data <= i_ioctl_dout;
      end
      if (w_dl_rise)                         r_count <= '0;
      else if (w_ack && (r_count != '1))     r_count <= r_count + ADDR_W'(1);
      if (w_dl_rise)                         r_err <= 1'b0;
      else if (w_bad_wr || (r_state == S_CHECK && r_count != TOTAL_SIZE)) r_err <= 1'b1;
      if (r_state != S_HOLD) r_hold <= '0;
      else                   r_hold <= r_hold + HOLD_W'(1);
    end
  end

  assign o_ioctl_wait = r_full;
  assign o_rom_we     = r_we;
  assign o_rom_addr   = r_addr;
  assign o_rom_data   = r_data;
  assign o_load_err   = r_err;
endmodule
